crash_arbiter: RTL and testbench
================================

# crash_arbiter

Round and match controller that sits directly downstream of the per-player edge detectors in the lightbike game. It collects each player's one-pixel `edge_detected` hits over a VGA frame and confirms a crash after a configurable number of consecutive hit frames. It then freezes the bikes, scores the round, holds the crash display, and either restarts the round or declares the match over. Its outputs enable bike movement and trigger clearing of the trail memory.

## Interface
Parameters:
- CONFIRM_FRAMES, 2: consecutive frames with a hit required to confirm a crash (1..7)
- HOLD_FRAMES, 120: frames spent in crash display before the next round (1..255)
- WIN_SCORE, 5: round wins needed to win the match (1..7)

Ports:
- clock  in  1  system/pixel clock
- reset  in  1  synchronous, active-high; all state and outputs return to reset values on the next edge
- start  in  1  start button, level; only its rising edge is used
- frame_end  in  1  one-cycle pulse after the last visible pixel of each frame
- edge_detected_p1  in  1  player 1 edge-detector output, pulses during scan
- edge_detected_p2  in  1  player 2 edge-detector output
- game_active  out  1  bike movement enable
- clear_trails  out  1  one-cycle pulse; trail memory wipe request
- round_winner  out  2  00 none, 01 P1, 10 P2, 11 draw
- score_p1  out  3  P1 round wins
- score_p2  out  3  P2 round wins
- game_over  out  1  match finished
- state  out  2  FSM state, for debug/display

## Operation
- Start detect: `start_q` is a register. The reset value of `start_q` is 1, so a button held through reset does not start a match. The rising edge is `start & ~start_q`.
- Hit flags `hit1` and `hit2` are sticky and set by the edge_detected inputs, only in PLAY. A hit in the same cycle as frame_end belongs to the frame being closed.
- At frame_end in PLAY, each player's confirm counter (3 bits) is updated. It increments if that player's effective hit (flag OR current input) is set, and clears to 0 otherwise. Both flags clear on this cycle.
- Crash for a player is confirmed when its counter, after the update, equals CONFIRM_FRAMES.
- FSM states:
  - IDLE (00): all outputs low. A start edge moves to PLAY, pulses clear_trails, and zeroes the scores.
  - PLAY (01): game_active = 1. A confirmed crash moves to HOLD and latches round_winner:
    - P1 only crashed: round_winner = P2 (10), score_p2 += 1.
    - P2 only crashed: round_winner = P1 (01), score_p1 += 1.
    - Both crash at the same frame_end: round_winner = draw (11), no score change.
    - Scores saturate at WIN_SCORE.
    - start is ignored in PLAY.
  - HOLD (10): game_active = 0. The hold counter (8 bits) counts frame_end pulses. On the HOLD_FRAMES-th pulse:
    - If either score equals WIN_SCORE, move to OVER.
    - Otherwise move to PLAY, pulse clear_trails, clear round_winner, and zero the confirm counters and flags.
  - OVER (11): game_over = 1 and round_winner stays latched. A start edge zeroes the scores, clears round_winner and game_over, pulses clear_trails, and moves to PLAY.
- Reset at any time: state IDLE, all counters and flags 0, every output 0, start_q 1.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Crash latency: frame_end in cycle N; in cycle N+1 state = HOLD, game_active = 0, and the round_winner and score updates are visible.
- Start latency: start edge sampled in cycle N; in cycle N+1 state = PLAY, game_active = 1, and clear_trails = 1 for exactly that one cycle.
- HOLD exit: the HOLD_FRAMES-th frame_end in cycle N gives the new state in N+1. If the new state is PLAY, clear_trails pulses in N+1.
- A frame with no hits resets that player's confirm counter, so non-consecutive hit frames never confirm a crash.
- frame_end in IDLE or OVER has no effect.

## Test plan
All scenarios use CONFIRM_FRAMES=2, HOLD_FRAMES=3, WIN_SCORE=2.
- Reset held while start = 1, then released with start still high -> state stays 00 and game_active = 0. Drop start, raise it again -> next cycle state = 01, clear_trails high for 1 cycle, scores = 0.
- In PLAY, pulse edge_detected_p1 once in frame 1 only, then give frame 2 no hits -> no crash, state stays 01. Pulse p1 in frames 3 and 4 -> the cycle after frame 4's frame_end shows state = 10, round_winner = 10, score_p2 = 1, game_active = 0.
- In HOLD, give 3 frame_end pulses -> after the third, state = 01, clear_trails pulses, round_winner = 00. start pulses during HOLD are ignored.
- Both players hit in two consecutive frames, with p2's hit coincident with frame_end -> round_winner = 11 and both scores unchanged.
- P1 crashes twice (two rounds), then 3 frames of HOLD -> score_p2 = 2, state = 11, game_over = 1. A start edge -> scores 0, game_over 0, state 01, clear_trails pulse.
- Assert reset in HOLD with score_p1 = 1 -> next cycle all outputs 0, state 00, and the hold counter restarts from 0 on the next match.

Source files
------------

// File: rtl/crash_arbiter_if.sv
// Game-control bus between the lightbike round/match controller and its surroundings.
interface crash_arbiter_if;
    logic       start;
    logic       frame_end;
    logic       edge_detected_p1;
    logic       edge_detected_p2;
    logic       game_active;
    logic       clear_trails;
    logic [1:0] round_winner;
    logic [2:0] score_p1;
    logic [2:0] score_p2;
    logic       game_over;
    logic [1:0] state;

    modport slave (
        input  start, frame_end, edge_detected_p1, edge_detected_p2,
        output game_active, clear_trails, round_winner, score_p1, score_p2,
               game_over, state
    );

    modport master (
        output start, frame_end, edge_detected_p1, edge_detected_p2,
        input  game_active, clear_trails, round_winner, score_p1, score_p2,
               game_over, state
    );
endinterface

// File: rtl/crash_arbiter.sv
// Lightbike round/match controller: confirms crashes over consecutive frames,
// scores rounds, holds the crash display and restarts or ends the match.
module crash_arbiter #(
    parameter int unsigned CONFIRM_FRAMES = 2,
    parameter int unsigned HOLD_FRAMES    = 120,
    parameter int unsigned WIN_SCORE      = 5
) (
    input logic             clock,
    input logic             reset,
    crash_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned HOLD_W = 8;

    localparam logic [CNT_W-1:0]  LP_CONFIRM = CNT_W'(CONFIRM_FRAMES);
    localparam logic [CNT_W-1:0]  LP_WIN     = CNT_W'(WIN_SCORE);
    localparam logic [HOLD_W-1:0] LP_HOLD    = HOLD_W'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_HOLD = 2'b10,
        S_OVER = 2'b11
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic                r_start_q;
    logic                r_hit1,    w_hit1_nxt;
    logic                r_hit2,    w_hit2_nxt;
    logic [CNT_W-1:0]    r_cnt1,    w_cnt1_nxt;
    logic [CNT_W-1:0]    r_cnt2,    w_cnt2_nxt;
    logic [HOLD_W-1:0]   r_hold,    w_hold_nxt;
    logic [CNT_W-1:0]    r_score1,  w_score1_nxt;
    logic [CNT_W-1:0]    r_score2,  w_score2_nxt;
    logic [1:0]          r_winner,  w_winner_nxt;
    logic                r_active,  w_active_nxt;
    logic                r_clear,   w_clear_nxt;
    logic                r_over,    w_over_nxt;

    logic                w_start_edge;
    logic                w_eff1, w_eff2;
    logic [CNT_W-1:0]    w_cnt1_upd, w_cnt2_upd;
    logic                w_crash1, w_crash2;
    logic [HOLD_W-1:0]   w_hold_inc;
    logic                w_new_round;

    // Next-state, scoring and output decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_hit1_nxt   = r_hit1;
        w_hit2_nxt   = r_hit2;
        w_cnt1_nxt   = r_cnt1;
        w_cnt2_nxt   = r_cnt2;
        w_hold_nxt   = r_hold;
        w_score1_nxt = r_score1;
        w_score2_nxt = r_score2;
        w_winner_nxt = r_winner;
        w_clear_nxt  = 1'b0;
        w_new_round  = 1'b0;

        w_start_edge = bus.start & ~r_start_q;
        // A hit coincident with frame_end still counts for the closing frame.
        w_eff1     = r_hit1 | bus.edge_detected_p1;
        w_eff2     = r_hit2 | bus.edge_detected_p2;
        w_cnt1_upd = w_eff1 ? (r_cnt1 + CNT_W'(1)) : '0;
        w_cnt2_upd = w_eff2 ? (r_cnt2 + CNT_W'(1)) : '0;
        w_crash1   = (w_cnt1_upd == LP_CONFIRM);
        w_crash2   = (w_cnt2_upd == LP_CONFIRM);
        w_hold_inc = r_hold + HOLD_W'(1);

        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_new_round  = 1'b1;
                    w_score1_nxt = '0;
                    w_score2_nxt = '0;
                end
            end
            S_PLAY: begin
                if (bus.frame_end) begin
                    w_hit1_nxt = 1'b0;
                    w_hit2_nxt = 1'b0;
                    w_cnt1_nxt = w_cnt1_upd;
                    w_cnt2_nxt = w_cnt2_upd;
                    if (w_crash1 || w_crash2) begin
                        w_state_nxt = S_HOLD;
                        w_hold_nxt  = '0;
                        if (w_crash1 && w_crash2) begin
                            w_winner_nxt = 2'b11;
                        end else if (w_crash1) begin
                            w_winner_nxt = 2'b10;
                            if (r_score2 != LP_WIN) w_score2_nxt = r_score2 + CNT_W'(1);
                        end else begin
                            w_winner_nxt = 2'b01;
                            if (r_score1 != LP_WIN) w_score1_nxt = r_score1 + CNT_W'(1);
                        end
                    end
                end else begin
                    w_hit1_nxt = w_eff1;
                    w_hit2_nxt = w_eff2;
                end
            end
            S_HOLD: begin
                if (bus.frame_end) begin
                    w_hold_nxt = w_hold_inc;
                    if (w_hold_inc == LP_HOLD) begin
                        if ((r_score1 == LP_WIN) || (r_score2 == LP_WIN)) begin
                            w_state_nxt = S_OVER;
                        end else begin
                            w_new_round = 1'b1;
                        end
                    end
                end
            end
            S_OVER: begin
                if (w_start_edge) begin
                    w_new_round  = 1'b1;
                    w_score1_nxt = '0;
                    w_score2_nxt = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Every entry into PLAY starts a clean round with wiped trails.
        if (w_new_round) begin
            w_state_nxt  = S_PLAY;
            w_clear_nxt  = 1'b1;
            w_winner_nxt = 2'b00;
            w_hit1_nxt   = 1'b0;
            w_hit2_nxt   = 1'b0;
            w_cnt1_nxt   = '0;
            w_cnt2_nxt   = '0;
            w_hold_nxt   = '0;
        end

        w_active_nxt = (w_state_nxt == S_PLAY);
        w_over_nxt   = (w_state_nxt == S_OVER);
    end

    // State and registered outputs; start_q resets high so a held button is ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b1;
            r_hit1    <= 1'b0;
            r_hit2    <= 1'b0;
            r_cnt1    <= '0;
            r_cnt2    <= '0;
            r_hold    <= '0;
            r_score1  <= '0;
            r_score2  <= '0;
            r_winner  <= 2'b00;
            r_active  <= 1'b0;
            r_clear   <= 1'b0;
            r_over    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= bus.start;
            r_hit1    <= w_hit1_nxt;
            r_hit2    <= w_hit2_nxt;
            r_cnt1    <= w_cnt1_nxt;
            r_cnt2    <= w_cnt2_nxt;
            r_hold    <= w_hold_nxt;
            r_score1  <= w_score1_nxt;
            r_score2  <= w_score2_nxt;
            r_winner  <= w_winner_nxt;
            r_active  <= w_active_nxt;
            r_clear   <= w_clear_nxt;
            r_over    <= w_over_nxt;
        end
    end

    assign bus.game_active  = r_active;
    assign bus.clear_trails = r_clear;
    assign bus.round_winner = r_winner;
    assign bus.score_p1     = r_score1;
    assign bus.score_p2     = r_score2;
    assign bus.game_over    = r_over;
    assign bus.state        = r_state;
endmodule

// File: tb/tb_crash_arbiter.sv
// Bench for crash_arbiter: directed match scenarios with literal expectations,
// then random play, all tracked by a frame-level behavioural model.
module tb_crash_arbiter;
    localparam int unsigned CONF = 2;
    localparam int unsigned HOLD = 3;
    localparam int unsigned WIN  = 2;

    logic clock;
    logic reset;
    crash_arbiter_if bus ();

    crash_arbiter #(
        .CONFIRM_FRAMES (CONF),
        .HOLD_FRAMES    (HOLD),
        .WIN_SCORE      (WIN)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  cmp_en   = 1'b0;
    bit  start_v  = 1'b1;

    // Model of the match: phase 0 idle, 1 playing, 2 showing crash, 3 match over.
    int  m_phase, m_run1, m_run2, m_held, m_s1, m_s2, m_winner;
    bit  m_prev_start, m_seen1, m_seen2, m_clear;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_begin_round();
        m_phase  = 1;
        m_clear  = 1'b1;
        m_run1   = 0;
        m_run2   = 0;
        m_seen1  = 1'b0;
        m_seen2  = 1'b0;
        m_winner = 0;
    endtask

    // Advance the model on each clock with the inputs the DUT samples.
    always @(posedge clock) begin
        bit rise, c1, c2;
        if (reset) begin
            m_phase = 0; m_prev_start = 1'b1; m_run1 = 0; m_run2 = 0; m_held = 0;
            m_s1 = 0; m_s2 = 0; m_winner = 0; m_seen1 = 1'b0; m_seen2 = 1'b0; m_clear = 1'b0;
        end else begin
            rise = bus.start && !m_prev_start;
            m_prev_start = bus.start;
            m_clear = 1'b0;
            case (m_phase)
                0: if (rise) begin m_s1 = 0; m_s2 = 0; m_begin_round(); end
                1: begin
                    m_seen1 = m_seen1 || bus.edge_detected_p1;
                    m_seen2 = m_seen2 || bus.edge_detected_p2;
                    if (bus.frame_end) begin
                        m_run1 = m_seen1 ? m_run1 + 1 : 0;
                        m_run2 = m_seen2 ? m_run2 + 1 : 0;
                        m_seen1 = 1'b0;
                        m_seen2 = 1'b0;
                        c1 = (m_run1 == CONF);
                        c2 = (m_run2 == CONF);
                        if (c1 || c2) begin
                            m_phase = 2;
                            m_held  = 0;
                            if (c1 && c2) m_winner = 3;
                            else if (c1) begin m_winner = 2; if (m_s2 < WIN) m_s2++; end
                            else begin m_winner = 1; if (m_s1 < WIN) m_s1++; end
                        end
                    end
                end
                2: if (bus.frame_end) begin
                    m_held++;
                    if (m_held == HOLD) begin
                        if (m_s1 == WIN || m_s2 == WIN) m_phase = 3;
                        else m_begin_round();
                    end
                end
                default: if (rise) begin m_s1 = 0; m_s2 = 0; m_begin_round(); end
            endcase
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("state",        int'(bus.state),        m_phase);
            chk("game_active",  int'(bus.game_active),  int'(m_phase == 1));
            chk("game_over",    int'(bus.game_over),    int'(m_phase == 3));
            chk("clear_trails", int'(bus.clear_trails), int'(m_clear));
            chk("round_winner", int'(bus.round_winner), m_winner);
            chk("score_p1",     int'(bus.score_p1),     m_s1);
            chk("score_p2",     int'(bus.score_p2),     m_s2);
        end
    end

    task automatic drive(input bit fe, input bit e1, input bit e2);
        bus.start            = start_v;
        bus.frame_end        = fe;
        bus.edge_detected_p1 = e1;
        bus.edge_detected_p2 = e2;
        @(posedge clock);
        #1;
    endtask

    // One frame: a mid-scan hit pulse, optional start toggle, then frame_end with optional coincident hits.
    task automatic frame(input bit h1, input bit h2, input bit c1, input bit c2, input bit ps);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, h1, h2);
        if (ps) start_v = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        if (ps) start_v = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, c1, c2);
    endtask

    task automatic start_edge();
        start_v = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        start_v = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start_v = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
        chk("lit_held_start_state", int'(bus.state), 0);
        chk("lit_held_start_active", int'(bus.game_active), 0);

        start_edge();
        chk("lit_start_state", int'(bus.state), 1);
        chk("lit_start_clear", int'(bus.clear_trails), 1);
        chk("lit_start_active", int'(bus.game_active), 1);
        chk("lit_start_score2", int'(bus.score_p2), 0);
        drive(1'b0, 1'b0, 1'b0);
        chk("lit_clear_one_cycle", int'(bus.clear_trails), 0);

        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_nonconsec_state", int'(bus.state), 1);
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_crash_state", int'(bus.state), 2);
        chk("lit_crash_winner", int'(bus.round_winner), 2);
        chk("lit_crash_score2", int'(bus.score_p2), 1);
        chk("lit_crash_active", int'(bus.game_active), 0);

        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_hold_still", int'(bus.state), 2);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_hold_exit_state", int'(bus.state), 1);
        chk("lit_hold_exit_clear", int'(bus.clear_trails), 1);
        chk("lit_hold_exit_winner", int'(bus.round_winner), 0);

        frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lit_draw_winner", int'(bus.round_winner), 3);
        chk("lit_draw_score1", int'(bus.score_p1), 0);
        chk("lit_draw_score2", int'(bus.score_p2), 1);
        for (int i = 0; i < 3; i++) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lit_win_score2", int'(bus.score_p2), 2);
        for (int i = 0; i < 3; i++) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_over_state", int'(bus.state), 3);
        chk("lit_over_flag", int'(bus.game_over), 1);
        chk("lit_over_winner", int'(bus.round_winner), 2);
        frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_over_frame_ignored", int'(bus.state), 3);
        start_edge();
        chk("lit_restart_state", int'(bus.state), 1);
        chk("lit_restart_score2", int'(bus.score_p2), 0);
        chk("lit_restart_over", int'(bus.game_over), 0);
        chk("lit_restart_clear", int'(bus.clear_trails), 1);

        frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_p2crash_score1", int'(bus.score_p1), 1);
        chk("lit_p2crash_winner", int'(bus.round_winner), 1);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("lit_rst_state", int'(bus.state), 0);
        chk("lit_rst_score1", int'(bus.score_p1), 0);
        chk("lit_rst_winner", int'(bus.round_winner), 0);
        frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("lit_idle_frame_ignored", int'(bus.state), 0);
        start_edge();
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_hold_restart_two", int'(bus.state), 2);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_hold_restart_three", int'(bus.state), 1);

        // Random play against the model.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 24) == 0) start_v = ~start_v;
            drive(($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 7) == 0));
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
